// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N:1 valid/ready stream multiplexer with round-robin arbitration and a
//   single registered output stage. Each output word carries the index of
//   the channel it came from. Sustains one word per cycle; a word appears
//   on the output one cycle after it is accepted.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   [N]        per-channel word present
//   in_data    [N*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   in_ready   [N]        per-channel word accepted this cycle (one-hot or 0)
//   out_valid             output register holds a word
//   out_data   [WIDTH]    registered word
//   out_sel    [SEL_W]    source channel of out_data
//   out_ready             consumer takes out_data this cycle

module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_sel_q,   out_sel_d;
  // index of the most recently granted channel
  logic [SEL_W-1:0]   ptr_q,       ptr_d;

  logic [WIDTH-1:0]   ch_data [N];
  logic               load_en;
  logic               grant_found;
  logic [SEL_W-1:0]   grant_idx;
  logic [SEL_W:0]     cand_sum;
  logic [SEL_W-1:0]   cand;
  logic               take;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Output register can accept a new word when empty or being drained now.
  assign load_en = !out_valid_q || out_ready;

  // Round-robin scan starting just after the last grant. The sum is one bit
  // wider than the index so a single conditional subtract gives the modulo
  // for any N, not only powers of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (cand_sum >= (SEL_W+1)'(N)) begin
        cand_sum = cand_sum - (SEL_W+1)'(N);
      end
      cand = cand_sum[SEL_W-1:0];
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign take     = !rst && load_en && grant_found;
  assign in_ready = take ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_found) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_data[grant_idx];
        out_sel_d   = grant_idx;
        ptr_d       = grant_idx;
      end else begin
        // data/sel/ptr keep their last values; only the valid flag drops
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      // N-1 so the first scan after reset starts at channel 0
      ptr_q       <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
